// File: rtl/instruction_cache_pkg.sv
// Shared types and address-slicing constants for the direct-mapped instruction cache.
package instruction_cache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  localparam int BLOCK_BITS  = 128;
  localparam int WORD_BITS   = 32;
  localparam int OFFSET_W    = 2;                     // word-within-block offset
  localparam int BYTE_OFF_W  = 2;                     // byte-within-word offset (ignored)
  localparam int BLOCK_OFF_W = OFFSET_W + BYTE_OFF_W; // low address bits below the index

  // Width of the block address {tag,index} for a given byte-address width.
  function automatic int blk_addr_width(input int addr_w);
    return addr_w - BLOCK_OFF_W;
  endfunction

  // Width of the stored tag for a given byte-address width and index width.
  function automatic int tag_width(input int addr_w, input int index_w);
    return addr_w - BLOCK_OFF_W - index_w;
  endfunction

endpackage

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache. Hits return a word combinationally;
// misses stall the CPU while one 128-bit block is fetched from instruction memory.
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int INDEX_W = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic [ADDR_W-1:0]     address,
  output logic [WORD_BITS-1:0]  instruction,
  output logic                  busywait,
  output logic                  mem_read,
  output logic [ADDR_W-5:0]     mem_address,
  input  logic [BLOCK_BITS-1:0] mem_readdata,
  input  logic                  mem_busywait
);

  localparam int BLK_W = blk_addr_width(ADDR_W);
  localparam int TAG_W = tag_width(ADDR_W, INDEX_W);
  localparam int LINES = 2 ** INDEX_W;

  state_t state, state_next;

  // Line storage: data and tags are don't-care until the valid bit is set.
  logic [BLOCK_BITS-1:0] data_arr [LINES];
  logic [TAG_W-1:0]      tag_arr  [LINES];
  logic [LINES-1:0]      valid;

  logic [BLK_W-1:0]      miss_blk;
  logic [BLOCK_BITS-1:0] fill_buf;

  logic [OFFSET_W-1:0] addr_offset;
  logic [INDEX_W-1:0]  addr_index;
  logic [TAG_W-1:0]    addr_tag;
  logic [BLK_W-1:0]    addr_blk;
  logic [INDEX_W-1:0]  miss_index;
  logic [TAG_W-1:0]    miss_tag;
  logic [BLOCK_BITS-1:0] cur_line;
  logic                hit;
  logic                unused_byte_bits;

  assign addr_offset = address[BLOCK_OFF_W-1:BYTE_OFF_W];
  assign addr_index  = address[BLOCK_OFF_W +: INDEX_W];
  assign addr_tag    = address[ADDR_W-1 -: TAG_W];
  assign addr_blk    = address[ADDR_W-1:BLOCK_OFF_W];
  assign miss_index  = miss_blk[INDEX_W-1:0];
  assign miss_tag    = miss_blk[BLK_W-1 -: TAG_W];

  // Instructions are word-aligned, so the byte-select bits carry no information.
  assign unused_byte_bits = ^address[BYTE_OFF_W-1:0];

  // Lookup: tag compare and word select, both combinational through the arrays.
  always_comb begin
    cur_line    = data_arr[addr_index];
    hit         = read & valid[addr_index] & (tag_arr[addr_index] == addr_tag);
    instruction = cur_line[{addr_offset, 5'd0} +: WORD_BITS];
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state: miss -> fetch block -> write line -> back to lookup.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (read && !hit)  state_next = MEM_READ;
      MEM_READ: if (!mem_busywait) state_next = UPDATE;
      UPDATE:                      state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  // FSM outputs: mem_read decodes the registered state, so it is a clean level.
  always_comb begin
    mem_read    = 1'b0;
    busywait    = 1'b1;
    mem_address = miss_blk;
    case (state)
      IDLE:     busywait = read & ~hit;
      MEM_READ: mem_read = 1'b1;
      default:  busywait = 1'b1;
    endcase
  end

  // Miss register: the fill target is frozen here so later address changes cannot redirect it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                           miss_blk <= '0;
    else if (state == IDLE && read && !hit) miss_blk <= addr_blk;
  end

  // Valid bits: cleared by reset, set when a line is written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 valid <= '0;
    else if (state == UPDATE)  valid[miss_index] <= 1'b1;
  end

  // Data path: capture the returned block, then commit it with its tag one cycle later.
  always_ff @(posedge clock) begin
    if (state == MEM_READ && !mem_busywait) fill_buf <= mem_readdata;
    if (state == UPDATE) begin
      data_arr[miss_index] <= fill_buf;
      tag_arr[miss_index]  <= miss_tag;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a block-read memory model.
module tb_instruction_cache;

  localparam int BUSY_CYC = 5;

  logic         clock = 1'b0;
  logic         reset;
  logic         read;
  logic [9:0]   address;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int tests_run    = 0;
  int tests_failed = 0;
  int busy_cnt;

  instruction_cache #(.ADDR_W(10), .INDEX_W(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .address      (address),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  always #5 clock = ~clock;

  // Block contents: block 0 is hand-picked, others are 0xB000_0000 | block<<8 | word.
  function automatic logic [127:0] blk(input logic [5:0] b);
    logic [127:0] r;
    if (b == 6'd0) begin
      r = {32'h22222222, 32'h11111111, 32'h00020008, 32'h00000007};
    end else begin
      for (int k = 0; k < 4; k++)
        r[32*k +: 32] = 32'hB000_0000 + ({26'd0, b} << 8) + k;
    end
    return r;
  endfunction

  // Memory model: busy for BUSY_CYC cycles after mem_read rises.
  always @(posedge clock or posedge reset) begin
    if (reset || !mem_read) busy_cnt <= 0;
    else                    busy_cnt <= busy_cnt + 1;
  end
  assign mem_busywait = mem_read && (busy_cnt < BUSY_CYC);
  assign mem_readdata = blk(mem_address);

  // Follow a fill from a MEM_READ cycle through UPDATE to the next IDLE cycle.
  task automatic fill_wait(output int mr, output logic stable, output logic upd_busy);
    logic [5:0] a0;
    a0 = mem_address;
    mr = 0;
    stable = 1'b1;
    while (mem_read === 1'b1 && mr < 100) begin
      mr++;
      if (mem_address !== a0) stable = 1'b0;
      @(negedge clock); #1;
    end
    upd_busy = busywait;
    @(negedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; read = 1'b0; address = '0;
    repeat (2) @(negedge clock);
    #1;
    tests_run++;
    if (busywait !== 1'b0) begin tests_failed++; $display("FAIL reset_busywait got %b want 0", busywait); end
    tests_run++;
    if (mem_read !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_read got %b want 0", mem_read); end
    tests_run++;
    if (mem_address !== 6'h00) begin tests_failed++; $display("FAIL reset_mem_address got %h want 00", mem_address); end
    reset = 1'b0;
    @(negedge clock); #1;
  endtask

  task automatic test_cold_miss();
    int mr; logic st, ub;
    read = 1'b1; address = 10'h000; #1;
    tests_run++;
    if (busywait !== 1'b1) begin tests_failed++; $display("FAIL cold_busywait got %b want 1", busywait); end
    tests_run++;
    if (mem_read !== 1'b0) begin tests_failed++; $display("FAIL cold_mem_read_idle got %b want 0", mem_read); end
    @(negedge clock); #1;
    tests_run++;
    if (mem_read !== 1'b1) begin tests_failed++; $display("FAIL cold_mem_read got %b want 1", mem_read); end
    tests_run++;
    if (mem_address !== 6'h00) begin tests_failed++; $display("FAIL cold_mem_address got %h want 00", mem_address); end
    fill_wait(mr, st, ub);
    tests_run++;
    if (mr !== 6) begin tests_failed++; $display("FAIL cold_mem_read_cycles got %0d want 6", mr); end
    tests_run++;
    if (ub !== 1'b1) begin tests_failed++; $display("FAIL cold_update_busywait got %b want 1", ub); end
    tests_run++;
    if (busywait !== 1'b0) begin tests_failed++; $display("FAIL cold_hit_busywait got %b want 0", busywait); end
    tests_run++;
    if (instruction !== 32'h00000007) begin tests_failed++; $display("FAIL cold_instruction got %h want 00000007", instruction); end
  endtask

  task automatic test_hit();
    address = 10'h004; #1;
    tests_run++;
    if (busywait !== 1'b0) begin tests_failed++; $display("FAIL hit_busywait got %b want 0", busywait); end
    tests_run++;
    if (instruction !== 32'h00020008) begin tests_failed++; $display("FAIL hit_word1 got %h want 00020008", instruction); end
    address = 10'h008; #1;
    tests_run++;
    if (instruction !== 32'h11111111) begin tests_failed++; $display("FAIL hit_word2 got %h want 11111111", instruction); end
    address = 10'h00F; #1;
    tests_run++;
    if (instruction !== 32'h22222222) begin tests_failed++; $display("FAIL hit_word3 got %h want 22222222", instruction); end
    @(negedge clock); #1;
    tests_run++;
    if (mem_read !== 1'b0) begin tests_failed++; $display("FAIL hit_mem_read got %b want 0", mem_read); end
  endtask

  task automatic test_conflict();
    int mr; logic st, ub;
    address = 10'h080; #1;
    tests_run++;
    if (busywait !== 1'b1) begin tests_failed++; $display("FAIL conflict_busywait got %b want 1", busywait); end
    @(negedge clock); #1;
    tests_run++;
    if (mem_address !== 6'h08) begin tests_failed++; $display("FAIL conflict_mem_address got %h want 08", mem_address); end
    fill_wait(mr, st, ub);
    tests_run++;
    if (instruction !== 32'hB0000800 || busywait !== 1'b0) begin
      tests_failed++; $display("FAIL conflict_instruction got %h/%b want B0000800/0", instruction, busywait);
    end
    address = 10'h000; #1;
    tests_run++;
    if (busywait !== 1'b1) begin tests_failed++; $display("FAIL conflict_evicted got %b want 1", busywait); end
    @(negedge clock); #1;
    tests_run++;
    if (mem_address !== 6'h00) begin tests_failed++; $display("FAIL conflict_refetch_address got %h want 00", mem_address); end
    fill_wait(mr, st, ub);
    tests_run++;
    if (instruction !== 32'h00000007 || busywait !== 1'b0) begin
      tests_failed++; $display("FAIL conflict_refill got %h/%b want 00000007/0", instruction, busywait);
    end
  endtask

  task automatic test_reset_mid_fill();
    int mr; logic st, ub;
    address = 10'h010; #1;
    @(negedge clock); #1;
    tests_run++;
    if (mem_read !== 1'b1 || mem_address !== 6'h01) begin
      tests_failed++; $display("FAIL rst_mid_request got %b/%h want 1/01", mem_read, mem_address);
    end
    @(negedge clock); #1;
    reset = 1'b1; #1;
    tests_run++;
    if (mem_read !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_mem_read got %b want 0", mem_read); end
    tests_run++;
    if (mem_address !== 6'h00) begin tests_failed++; $display("FAIL rst_mid_mem_address got %h want 00", mem_address); end
    @(negedge clock); #1;
    reset = 1'b0; #1;
    tests_run++;
    if (busywait !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_line1_unwritten got %b want 1", busywait); end
    address = 10'h000; #1;
    tests_run++;
    if (busywait !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_valid_cleared got %b want 1", busywait); end
    @(negedge clock); #1;
    tests_run++;
    if (mem_address !== 6'h00) begin tests_failed++; $display("FAIL rst_mid_refetch got %h want 00", mem_address); end
    fill_wait(mr, st, ub);
    tests_run++;
    if (mr !== 6) begin tests_failed++; $display("FAIL rst_mid_cycles got %0d want 6", mr); end
    tests_run++;
    if (instruction !== 32'h00000007) begin tests_failed++; $display("FAIL rst_mid_instruction got %h want 00000007", instruction); end
  endtask

  task automatic test_addr_change();
    int mr; logic st, ub;
    address = 10'h020; #1;
    @(negedge clock); #1;
    tests_run++;
    if (mem_address !== 6'h02) begin tests_failed++; $display("FAIL chg_mem_address got %h want 02", mem_address); end
    address = 10'h030;
    fill_wait(mr, st, ub);
    tests_run++;
    if (st !== 1'b1) begin tests_failed++; $display("FAIL chg_address_stable got %b want 1", st); end
    tests_run++;
    if (mr !== 6) begin tests_failed++; $display("FAIL chg_cycles got %0d want 6", mr); end
    tests_run++;
    if (busywait !== 1'b1) begin tests_failed++; $display("FAIL chg_new_miss got %b want 1", busywait); end
    @(negedge clock); #1;
    tests_run++;
    if (mem_address !== 6'h03) begin tests_failed++; $display("FAIL chg_second_address got %h want 03", mem_address); end
    fill_wait(mr, st, ub);
    tests_run++;
    if (instruction !== 32'hB0000300 || busywait !== 1'b0) begin
      tests_failed++; $display("FAIL chg_line3 got %h/%b want B0000300/0", instruction, busywait);
    end
    address = 10'h024; #1;
    tests_run++;
    if (instruction !== 32'hB0000201 || busywait !== 1'b0) begin
      tests_failed++; $display("FAIL chg_line2 got %h/%b want B0000201/0", instruction, busywait);
    end
  endtask

  task automatic test_idle_no_read();
    read = 1'b0;
    for (int i = 0; i < 10; i++) begin
      address = 10'(i * 97 + 3); #1;
      tests_run++;
      if (busywait !== 1'b0 || mem_read !== 1'b0) begin
        tests_failed++; $display("FAIL noread_%0d got %b/%b want 0/0", i, busywait, mem_read);
      end
      @(negedge clock); #1;
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_reset_mid_fill();
    test_addr_change();
    test_idle_no_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
